// File: rtl/sample_trigger.sv
// Trigger front-end for the sampler: delays the probe bus by two cycles and
// holds the sampler's write reset low until a programmable pattern fires.
module sample_trigger #(
  parameter int unsigned width     = 32,
  parameter int unsigned countBits = 16
) (
  input  logic                 w_clk,
  input  logic                 w_reset_n,
  input  logic [width-1:0]     w_in,
  input  logic [width-1:0]     cfg_value,
  input  logic [width-1:0]     cfg_mask,
  input  logic [width-1:0]     cfg_rise,
  input  logic [width-1:0]     cfg_fall,
  input  logic [countBits-1:0] cfg_count,
  input  logic [countBits-1:0] cfg_delay,
  input  logic                 cfg_force,
  output logic [width-1:0]     s_data,
  output logic                 s_reset_n,
  output logic                 armed,
  output logic                 triggered,
  output logic [countBits-1:0] match_count
);

  localparam int unsigned CW1 = countBits + 1;

  localparam logic [1:0] PRIME = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DELAY = 2'd2;
  localparam logic [1:0] RUN   = 2'd3;

  logic [1:0]           state;
  logic [1:0]           state_nx;
  logic [width-1:0]     d1;
  logic [width-1:0]     d2;
  logic                 force_m;
  logic                 force_s;
  logic [width-1:0]     value_q;
  logic [width-1:0]     mask_q;
  logic [width-1:0]     rise_q;
  logic [width-1:0]     fall_q;
  logic [countBits-1:0] count_q;
  logic [countBits-1:0] delay_q;
  logic [countBits-1:0] dcnt;
  logic [countBits-1:0] dcnt_nx;
  logic [countBits-1:0] match_count_nx;
  logic                 s_reset_n_nx;
  logic                 triggered_nx;
  logic                 armed_nx;
  logic                 match_c;
  logic                 fire_c;
  logic [CW1-1:0]       cnt_inc_c;
  logic [CW1-1:0]       cnt_need_c;

  // Probe pipeline and force synchronizer run regardless of reset.
  always_ff @(posedge w_clk) begin
    d1      <= w_in;
    d2      <= d1;
    s_data  <= d1;
    force_m <= cfg_force;
    force_s <= force_m;
  end

  // Configuration is transparent only while disarmed.
  always_ff @(posedge w_clk) begin
    if (!w_reset_n) begin
      value_q <= cfg_value;
      mask_q  <= cfg_mask;
      rise_q  <= cfg_rise;
      fall_q  <= cfg_fall;
      count_q <= cfg_count;
      delay_q <= cfg_delay;
    end
  end

  always_comb begin
    match_c = (((d1 ^ value_q) & mask_q) == '0) &&
              ((rise_q & ~(d1 & ~d2)) == '0) &&
              ((fall_q & ~(~d1 & d2)) == '0);
    cnt_inc_c  = {1'b0, match_count} + CW1'(1);
    cnt_need_c = (count_q == '0) ? CW1'(1) : {1'b0, count_q};
    fire_c     = (match_c && (cnt_inc_c >= cnt_need_c)) || force_s;
  end

  always_ff @(posedge w_clk) begin
    if (!w_reset_n) state <= PRIME;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    dcnt_nx        = dcnt;
    match_count_nx = match_count;
    s_reset_n_nx   = s_reset_n;
    triggered_nx   = triggered;
    case (state)
      PRIME: state_nx = WAIT;
      WAIT: begin
        if (match_c && !(&match_count))
          match_count_nx = match_count + countBits'(1);
        if (fire_c) begin
          if (delay_q == '0) begin
            state_nx     = RUN;
            s_reset_n_nx = 1'b1;
            triggered_nx = 1'b1;
          end else begin
            state_nx = DELAY;
            dcnt_nx  = delay_q;
          end
        end
      end
      DELAY: begin
        dcnt_nx = dcnt - countBits'(1);
        if (dcnt == countBits'(1)) begin
          state_nx     = RUN;
          s_reset_n_nx = 1'b1;
          triggered_nx = 1'b1;
        end
      end
      default: state_nx = RUN;
    endcase
    armed_nx = (state_nx == WAIT) || (state_nx == DELAY);
  end

  always_ff @(posedge w_clk) begin
    if (!w_reset_n) begin
      dcnt        <= '0;
      match_count <= '0;
      s_reset_n   <= 1'b0;
      triggered   <= 1'b0;
      armed       <= 1'b0;
    end else begin
      dcnt        <= dcnt_nx;
      match_count <= match_count_nx;
      s_reset_n   <= s_reset_n_nx;
      triggered   <= triggered_nx;
      armed       <= armed_nx;
    end
  end

endmodule

// File: doc/sample_trigger.md
Name: sample_trigger

Overview:
- Sits directly upstream of the sampler, in the w_clk domain.
- Watches the raw probe bus and delays it by two cycles onto s_data.
- Holds the sampler's write reset low until a programmable trigger fires: level/edge pattern, Nth occurrence, plus post-trigger delay.
- The first sample the sampler stores is the triggering sample, or the sample D cycles after it when a delay of D is set.

Parameters:
width, 32, probe bus width; must match the sampler width.
countBits, 16, width of the occurrence and delay counters.

Ports:
w_clk  in  1  sample clock.
w_reset_n  in  1  synchronous, active-low reset on w_clk; low = disarmed; rising = arm.
w_in  in  width  raw probe bus.
cfg_value  in  width  level compare value.
cfg_mask  in  width  1 = bit must equal cfg_value.
cfg_rise  in  width  1 = bit must rise (0 to 1) this sample.
cfg_fall  in  width  1 = bit must fall (1 to 0) this sample.
cfg_count  in  countBits  matches required to trigger; 0 treated as 1.
cfg_delay  in  countBits  samples between trigger and recording start.
cfg_force  in  1  asynchronous force-trigger request, level.
s_data  out  width  w_in delayed 2 cycles; drives sampler w_in.
s_reset_n  out  1  drives sampler w_reset_n; high = record.
armed  out  1  high in WAIT or DELAY.
triggered  out  1  high once RUN is entered.
match_count  out  countBits  matches seen since arm; saturating.

Behaviour:
Config capture:
- All cfg_* except cfg_force are registered every cycle while w_reset_n is low.
- They are frozen while w_reset_n is high, so software may change them only while disarmed.

Data pipeline (runs continuously, including during reset):
- d1 <= w_in; s_data <= d1; d2 <= d1.
- The match is evaluated on cur = d1, prev = d2.

Match condition (combinational): all three must hold.
- ((cur ^ value) & mask) == 0
- (rise & ~(cur & ~prev)) == 0
- (fall & ~(~cur & prev)) == 0
- With all masks 0, every sample matches.

cfg_force:
- Passes through a 2-flop synchronizer inside the block.
- Synchronized level high in WAIT = immediate trigger, ignoring cfg_count.

State machine: states PRIME, WAIT, DELAY, RUN.
Reset (w_reset_n low at an edge) forces:
- state = PRIME;
- s_reset_n = 0, triggered = 0, armed = 0;
- match_count = 0, delay counter = 0.

Transitions and outputs:
- PRIME: one cycle with no match evaluation, so prev is valid. Goes to WAIT.
- WAIT: on match, match_count increments (saturating at 2^countBits-1).
- WAIT triggers if match_count+1 >= max(cfg_count,1) or force is set. On trigger:
  - D = 0: go to RUN; s_reset_n <= 1 and triggered <= 1 at this same edge.
  - D > 0: go to DELAY with counter = D.
- DELAY: counter decrements each cycle; at counter == 1, go to RUN with s_reset_n <= 1 and triggered <= 1.
- RUN: holds. s_reset_n stays 1 until w_reset_n goes low; no further matches are counted.

Alignment:
- When s_reset_n rises at edge k, s_data at edge k holds the trigger sample (plus D).
- The sampler therefore writes that sample first at edge k+1.
- Minimum arm-to-record latency: 3 cycles (PRIME, WAIT-match, RUN).

Boundary rules:
- Reset mid-DELAY or mid-RUN: s_reset_n drops at that edge and the sampler restarts; no partial trigger state survives.
- Match and force in the same cycle: trigger once; match_count still increments.
- cfg_delay = 2^countBits-1 is legal; no wrap to 0.

Test Plan:
1. mask=0xFF, value=0x5A, count=1, delay=0; ramp w_in 0x00,0x01,… -> s_reset_n rises at the edge where s_data==0x5A; sampler word 0 = 0x5A; match_count=1.
2. rise=0x1, toggle bit0 every cycle, count=3 -> trigger on the 3rd rising edge after PRIME; match_count=3; no match in the PRIME cycle even if bit0 was 1.
3. Case 1 with delay=4 -> s_reset_n rises 4 cycles later than in case 1; first stored sample = 0x5E; armed high through DELAY.
4. Impossible pattern (mask=1, value=1, w_in=0), pulse cfg_force for 3 w_clk -> trigger within 3–4 cycles; triggered=1; match_count=0.
5. Drop w_reset_n for one cycle while in DELAY -> s_reset_n=0, triggered=0, armed=0 next edge; new config values are latched; re-arm works from PRIME.
6. cfg_count=0, all masks 0 -> triggers on the first WAIT cycle (3 cycles after arm); match_count=1.
